debug_data_sender: RTL and testbench



---
 rtl/debug_data_sender.sv | 208 ++++++++++++++++++++
 tb/tb_debug_data_sender.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_data_sender.sv
// Debug snapshot streamer: on request, sends PC, cycle count, register file and data memory
// MSB byte first to the UART TX. Optional trailing XOR checksum byte via DBG_SEND_CHECKSUM_EN.
//
// state      | meaning
// -----------+----------------------------------------------------------
// S_IDLE     | waiting for is_start_send, snapshot latched on accept
// S_LOAD     | debug read address for word w on the ports
// S_LATCH    | selected word captured, first byte staged with tx start
// S_SEND     | os_tx_start high for this single cycle
// S_WAIT_TX  | holding byte until is_tx_done
// S_CHK      | checksum byte tx start cycle (checksum build only)
// S_CHK_WAIT | waiting for checksum byte tx done (checksum build only)
// S_DONE     | os_done_send high for this single cycle
module debug_data_sender #(
    parameter int N_REGS      = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int N_MEM_WORDS = 32,
    parameter int MEM_ADDR_W  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_start_send,
    input  logic [31:0]           i_pc,
    input  logic [31:0]           i_clk_count,
    output logic [REG_ADDR_W-1:0] o_reg_addr,
    input  logic [31:0]           i_reg_data,
    output logic [MEM_ADDR_W-1:0] o_mem_addr,
    input  logic [31:0]           i_mem_data,
    output logic [7:0]            o_tx_data,
    output logic                  os_tx_start,
    input  logic                  is_tx_done,
    output logic                  os_done_send
);

    localparam int N_WORDS = 2 + N_REGS + N_MEM_WORDS;
    localparam int W_W     = $clog2(N_WORDS + 1);

    localparam logic [W_W-1:0] W_LAST = W_W'(N_WORDS - 1);
    localparam logic [W_W-1:0] W_CNT  = W_W'(1);
    localparam logic [W_W-1:0] W_REG0 = W_W'(2);
    localparam logic [W_W-1:0] W_MEM0 = W_W'(2 + N_REGS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_LATCH,
        S_SEND,
        S_WAIT_TX,
`ifdef DBG_SEND_CHECKSUM_EN
        S_CHK,
        S_CHK_WAIT,
`endif
        S_DONE
    } state_t;

    state_t         state;
    logic [W_W-1:0] w;
    logic [1:0]     b;
    logic [31:0]    word_q;
    logic [31:0]    pc_q;
    logic [31:0]    cnt_q;
`ifdef DBG_SEND_CHECKSUM_EN
    logic [7:0]     chk;
`endif

    logic [W_W-1:0] w_inc;
    logic [31:0]    sel_word;
    logic [1:0]     b_inc;
    logic [7:0]     next_byte;

    function automatic logic [7:0] byte_of(input logic [31:0] wd, input logic [1:0] idx);
        logic [7:0] r;
        r = wd[7:0];
        case (idx)
            2'd0:    r = wd[31:24];
            2'd1:    r = wd[23:16];
            2'd2:    r = wd[15:8];
            default: r = wd[7:0];
        endcase
        return r;
    endfunction

    assign w_inc     = w + W_W'(1);
    assign b_inc     = b + 2'd1;
    assign next_byte = byte_of(word_q, b_inc);

    // Read ports return data one cycle after the address, which is exactly the LATCH cycle.
    always_comb begin
        sel_word = i_mem_data;
        if (w == '0)
            sel_word = pc_q;
        else if (w == W_CNT)
            sel_word = cnt_q;
        else if (w < W_MEM0)
            sel_word = i_reg_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            w            <= '0;
            b            <= '0;
            word_q       <= '0;
            pc_q         <= '0;
            cnt_q        <= '0;
            o_reg_addr   <= '0;
            o_mem_addr   <= '0;
            o_tx_data    <= '0;
            os_tx_start  <= 1'b0;
            os_done_send <= 1'b0;
`ifdef DBG_SEND_CHECKSUM_EN
            chk          <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (is_start_send) begin
                        pc_q  <= i_pc;
                        cnt_q <= i_clk_count;
                        w     <= '0;
                        b     <= '0;
`ifdef DBG_SEND_CHECKSUM_EN
                        chk   <= '0;
`endif
                        state <= S_LOAD;
                    end
                end

                S_LOAD: begin
                    state <= S_LATCH;
                end

                S_LATCH: begin
                    word_q      <= sel_word;
                    b           <= '0;
                    o_tx_data   <= sel_word[31:24];
                    os_tx_start <= 1'b1;
`ifdef DBG_SEND_CHECKSUM_EN
                    chk         <= chk ^ sel_word[31:24];
`endif
                    state       <= S_SEND;
                end

                S_SEND: begin
                    os_tx_start <= 1'b0;
                    state       <= S_WAIT_TX;
                end

                S_WAIT_TX: begin
                    if (is_tx_done) begin
                        if (b != 2'd3) begin
                            b           <= b_inc;
                            o_tx_data   <= next_byte;
                            os_tx_start <= 1'b1;
`ifdef DBG_SEND_CHECKSUM_EN
                            chk         <= chk ^ next_byte;
`endif
                            state       <= S_SEND;
                        end else if (w == W_LAST) begin
`ifdef DBG_SEND_CHECKSUM_EN
                            o_tx_data   <= chk;
                            os_tx_start <= 1'b1;
                            state       <= S_CHK;
`else
                            os_done_send <= 1'b1;
                            state        <= S_DONE;
`endif
                        end else begin
                            // Address goes out on entry to LOAD so it is stable for the whole LOAD cycle.
                            w <= w_inc;
                            if (w_inc >= W_REG0 && w_inc < W_MEM0)
                                o_reg_addr <= REG_ADDR_W'(w_inc - W_REG0);
                            else if (w_inc >= W_MEM0)
                                o_mem_addr <= MEM_ADDR_W'(w_inc - W_MEM0);
                            state <= S_LOAD;
                        end
                    end
                end

`ifdef DBG_SEND_CHECKSUM_EN
                S_CHK: begin
                    os_tx_start <= 1'b0;
                    state       <= S_CHK_WAIT;
                end

                S_CHK_WAIT: begin
                    if (is_tx_done) begin
                        os_done_send <= 1'b1;
                        state        <= S_DONE;
                    end
                end
`endif

                S_DONE: begin
                    os_done_send <= 1'b0;
                    state        <= S_IDLE;
                end

                default: begin
                    os_tx_start  <= 1'b0;
                    os_done_send <= 1'b0;
                    state        <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_data_sender.sv
// Directed bench for debug_data_sender: register/memory read models, a UART TX model that
// answers 5 cycles after each start, and one task per scenario.
module tb_debug_data_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        is_start_send = 1'b0;
    logic [31:0] i_pc = '0;
    logic [31:0] i_clk_count = '0;
    logic [4:0]  o_reg_addr;
    logic [31:0] i_reg_data = '0;
    logic [4:0]  o_mem_addr;
    logic [31:0] i_mem_data = '0;
    logic [7:0]  o_tx_data;
    logic        os_tx_start;
    logic        is_tx_done = 1'b0;
    logic        os_done_send;

`ifdef DBG_SEND_CHECKSUM_EN
    localparam int N_TX = 265;
`else
    localparam int N_TX = 264;
`endif
    localparam int N_DATA = 264;

    int errors = 0;
    int checks = 0;

    // monitor-owned
    int         cyc = 0;
    logic [7:0] cap [0:4095];
    int         cap_n = 0;
    int         done_n = 0;
    int         done_cyc = 0;
    int         real_done_cyc = 0;
    bit         real_done_prev = 1'b0;
    int         cd = 0;
    logic [4:0] prev_reg = '0;
    logic [4:0] prev_mem = '0;
    int         ld_reg [0:79];
    int         ld_mem [0:79];
    int         first_start_cyc = 0;
    int         gap_err = 0;
    int         both_n = 0;

    // task-owned
    int cap_base = 0;
    int done_base = 0;
    int gap_base = 0;
    int kick_cyc = 0;
    bit spur_en = 1'b0;

    debug_data_sender dut (
        .clk          (clk),
        .rst          (rst),
        .is_start_send(is_start_send),
        .i_pc         (i_pc),
        .i_clk_count  (i_clk_count),
        .o_reg_addr   (o_reg_addr),
        .i_reg_data   (i_reg_data),
        .o_mem_addr   (o_mem_addr),
        .i_mem_data   (i_mem_data),
        .o_tx_data    (o_tx_data),
        .os_tx_start  (os_tx_start),
        .is_tx_done   (is_tx_done),
        .os_done_send (os_done_send)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

    function automatic logic [7:0] exp_byte(input int idx, input logic [31:0] pc, input logic [31:0] cnt);
        int w;
        int b;
        logic [31:0] wd;
        logic [31:0] s;
        w = idx / 4;
        b = idx % 4;
        if (w == 0)       wd = pc;
        else if (w == 1)  wd = cnt;
        else if (w < 34)  wd = 32'h100 + 32'(w - 2);
        else              wd = 32'hA000 + 32'(w - 34);
        s = wd >> (24 - 8 * b);
        return s[7:0];
    endfunction

    // Samples DUT outputs mid-cycle, then drives the read-port and TX models for this cycle.
    always @(negedge clk) begin
        int idx;
        bit nd;
        cyc++;
        idx = cap_n - cap_base;
        if (real_done_prev && (idx % 4 == 0) && idx / 4 < 80) begin
            ld_reg[idx / 4] = int'(o_reg_addr);
            ld_mem[idx / 4] = int'(o_mem_addr);
        end
        if (os_tx_start) begin
            if (idx == 0)
                first_start_cyc = cyc;
            else if (cyc - real_done_cyc != ((idx % 4 == 0 && idx < N_DATA) ? 3 : 1))
                gap_err++;
            if (cap_n < 4096) cap[cap_n] = o_tx_data;
            cap_n++;
        end
        if (os_done_send) begin
            done_n++;
            done_cyc = cyc;
        end
        if (os_tx_start && os_done_send) both_n++;

        i_reg_data = 32'h100 + 32'(prev_reg);
        i_mem_data = 32'hA000 + 32'(prev_mem);
        prev_reg = o_reg_addr;
        prev_mem = o_mem_addr;

        nd = 1'b0;
        is_tx_done = 1'b0;
        if (!rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    is_tx_done = 1'b1;
                    nd = 1'b1;
                    real_done_cyc = cyc;
                end
            end
            if (os_tx_start) cd = 5;
            if (spur_en && real_done_prev) is_tx_done = 1'b1;
        end
        real_done_prev = nd;
    end

    task automatic kick(input logic [31:0] pc, input logic [31:0] cnt);
        @(negedge clk); #2;
        kick_cyc      = cyc;
        cap_base      = cap_n;
        done_base     = done_n;
        gap_base      = gap_err;
        i_pc          = pc;
        i_clk_count   = cnt;
        is_start_send = 1'b1;
        @(negedge clk); #2;
        is_start_send = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        int n;
        n = 0;
        while (done_n == done_base && n < 5000) begin
            @(negedge clk); #2;
            n++;
        end
        to = (done_n == done_base);
        repeat (4) @(negedge clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk); #2;
        checks++; if (o_tx_data !== 8'h00)   begin errors++; $display("FAIL reset_tx_data: got %0h expected 0", o_tx_data); end
        checks++; if (os_tx_start !== 1'b0)  begin errors++; $display("FAIL reset_tx_start: got %0b expected 0", os_tx_start); end
        checks++; if (os_done_send !== 1'b0) begin errors++; $display("FAIL reset_done_send: got %0b expected 0", os_done_send); end
        checks++; if (o_reg_addr !== 5'd0)   begin errors++; $display("FAIL reset_reg_addr: got %0d expected 0", o_reg_addr); end
        checks++; if (o_mem_addr !== 5'd0)   begin errors++; $display("FAIL reset_mem_addr: got %0d expected 0", o_mem_addr); end
    endtask

    task automatic test_basic_stream();
        bit to;
        int bad;
        logic [7:0] e_head [0:11];
        logic [7:0] e_tail [0:3];
        logic [7:0] x;
        e_head = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h01, 8'h00};
        e_tail = '{8'h00, 8'h00, 8'hA0, 8'h1F};
        kick(32'h0000_0040, 32'h0000_0007);
        wait_done(to);
        checks++; if (to) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++; if (cap_n - cap_base != N_TX) begin errors++; $display("FAIL basic_count: got %0d expected %0d", cap_n - cap_base, N_TX); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (cap[cap_base + i] !== e_head[i]) begin errors++; $display("FAIL basic_byte%0d: got %0h expected %0h", i, cap[cap_base + i], e_head[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap[cap_base + 260 + i] !== e_tail[i]) begin errors++; $display("FAIL basic_tail%0d: got %0h expected %0h", i, cap[cap_base + 260 + i], e_tail[i]); end
        end
        bad = 0;
        for (int i = 0; i < N_DATA; i++)
            if (cap[cap_base + i] !== exp_byte(i, 32'h40, 32'h7)) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL basic_stream: got %0d bad bytes expected 0", bad); end
        checks++; if (done_n - done_base != 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_n - done_base); end
        checks++; if (done_cyc != real_done_cyc + 1) begin errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, real_done_cyc + 1); end
        checks++; if (first_start_cyc != kick_cyc + 3) begin errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", first_start_cyc, kick_cyc + 3); end
        checks++; if (gap_err != gap_base) begin errors++; $display("FAIL basic_gaps: got %0d gap errors expected 0", gap_err - gap_base); end
`ifdef DBG_SEND_CHECKSUM_EN
        x = 8'h00;
        for (int i = 0; i < N_DATA; i++) x ^= exp_byte(i, 32'h40, 32'h7);
        checks++; if (cap[cap_base + N_DATA] !== x) begin errors++; $display("FAIL checksum_byte: got %0h expected %0h", cap[cap_base + N_DATA], x); end
`else
        x = 8'h00;
`endif
    endtask

    // Relies on the capture of the basic stream run immediately before.
    task automatic test_address_timing();
        int bad_r;
        int bad_m;
        int bad_d;
        logic [31:0] wd;
        bad_r = 0; bad_m = 0; bad_d = 0;
        for (int k = 0; k < 32; k++) begin
            if (ld_reg[k + 2] != k) bad_r++;
            if (ld_mem[k + 34] != k) bad_m++;
            wd = {cap[cap_base + 4*(k+2)], cap[cap_base + 4*(k+2) + 1], cap[cap_base + 4*(k+2) + 2], cap[cap_base + 4*(k+2) + 3]};
            if (wd !== 32'h100 + 32'(k)) bad_d++;
        end
        checks++; if (bad_r != 0) begin errors++; $display("FAIL addr_reg_load: got %0d wrong expected 0 (word2 addr %0d)", bad_r, ld_reg[2]); end
        checks++; if (bad_m != 0) begin errors++; $display("FAIL addr_mem_load: got %0d wrong expected 0 (word34 addr %0d)", bad_m, ld_mem[34]); end
        checks++; if (bad_d != 0) begin errors++; $display("FAIL addr_reg_data: got %0d wrong words expected 0", bad_d); end
    endtask

    task automatic test_snapshot_hold();
        bit to;
        logic [31:0] pc_s;
        logic [31:0] cnt_s;
        kick(32'h0000_0040, 32'h0000_0007);
        i_pc = 32'hFFFF_FFFF;
        i_clk_count = 32'hFFFF_FFFF;
        wait_done(to);
        pc_s  = {cap[cap_base], cap[cap_base + 1], cap[cap_base + 2], cap[cap_base + 3]};
        cnt_s = {cap[cap_base + 4], cap[cap_base + 5], cap[cap_base + 6], cap[cap_base + 7]};
        checks++; if (to) begin errors++; $display("FAIL snap_timeout: got no done expected done"); end
        checks++; if (pc_s !== 32'h40) begin errors++; $display("FAIL snap_pc: got %0h expected 40", pc_s); end
        checks++; if (cnt_s !== 32'h7) begin errors++; $display("FAIL snap_count: got %0h expected 7", cnt_s); end
        checks++; if (cap_n - cap_base != N_TX) begin errors++; $display("FAIL snap_bytes: got %0d expected %0d", cap_n - cap_base, N_TX); end
    endtask

    task automatic test_ignored_inputs();
        bit to;
        bit hit;
        int n;
        int bad;
        spur_en = 1'b1;
        kick(32'hDEAD_BEEF, 32'h00C0_FFEE);
        n = 0;
        while (cap_n - cap_base < 40 && n < 2000) begin @(negedge clk); #2; n++; end
        is_start_send = 1'b1;
        @(negedge clk); #2;
        is_start_send = 1'b0;
        n = 0;
        while (cap_n - cap_base < 100 && n < 2000) begin @(negedge clk); #2; n++; end
        hit = 1'b0;
        n = 0;
        while (!hit && n < 50) begin
            @(negedge clk); #2;
            n++;
            if (is_tx_done) begin
                hit = 1'b1;
                is_start_send = 1'b1;
                @(negedge clk); #2;
                is_start_send = 1'b0;
            end
        end
        wait_done(to);
        spur_en = 1'b0;
        bad = 0;
        for (int i = 0; i < N_DATA; i++)
            if (cap[cap_base + i] !== exp_byte(i, 32'hDEAD_BEEF, 32'h00C0_FFEE)) bad++;
        checks++; if (to) begin errors++; $display("FAIL ign_timeout: got no done expected done"); end
        checks++; if (!hit) begin errors++; $display("FAIL ign_done_start_overlap: got no tx_done window expected one"); end
        checks++; if (cap_n - cap_base != N_TX) begin errors++; $display("FAIL ign_bytes: got %0d expected %0d", cap_n - cap_base, N_TX); end
        checks++; if (bad != 0) begin errors++; $display("FAIL ign_stream: got %0d bad bytes expected 0", bad); end
        checks++; if (done_n - done_base != 1) begin errors++; $display("FAIL ign_done_count: got %0d expected 1", done_n - done_base); end
        checks++; if (gap_err != gap_base) begin errors++; $display("FAIL ign_gaps: got %0d gap errors expected 0", gap_err - gap_base); end
    endtask

    task automatic test_reset_mid_stream();
        bit to;
        int n;
        logic [31:0] pc_s;
        kick(32'h0000_0040, 32'h0000_0007);
        n = 0;
        while (cap_n - cap_base < 11 && n < 2000) begin @(negedge clk); #2; n++; end
        checks++; if (cap_n - cap_base < 11) begin errors++; $display("FAIL mid_reach_byte10: got %0d bytes expected 11", cap_n - cap_base); end
        repeat (2) @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        checks++; if (o_tx_data !== 8'h00)   begin errors++; $display("FAIL mid_tx_data: got %0h expected 0", o_tx_data); end
        checks++; if (os_tx_start !== 1'b0)  begin errors++; $display("FAIL mid_tx_start: got %0b expected 0", os_tx_start); end
        checks++; if (os_done_send !== 1'b0) begin errors++; $display("FAIL mid_done_send: got %0b expected 0", os_done_send); end
        checks++; if (o_reg_addr !== 5'd0 || o_mem_addr !== 5'd0) begin errors++; $display("FAIL mid_addrs: got %0d/%0d expected 0/0", o_reg_addr, o_mem_addr); end
        repeat (4) @(negedge clk);
        #2;
        rst = 1'b1;
        repeat (6) @(negedge clk);
        #2;
        checks++; if (done_n != done_base) begin errors++; $display("FAIL mid_no_done: got %0d pulses expected 0", done_n - done_base); end
        kick(32'h1234_5678, 32'h9ABC_DEF0);
        wait_done(to);
        pc_s = {cap[cap_base], cap[cap_base + 1], cap[cap_base + 2], cap[cap_base + 3]};
        checks++; if (to) begin errors++; $display("FAIL mid_restart_timeout: got no done expected done"); end
        checks++; if (pc_s !== 32'h1234_5678) begin errors++; $display("FAIL mid_restart_pc: got %0h expected 12345678", pc_s); end
        checks++; if (cap_n - cap_base != N_TX) begin errors++; $display("FAIL mid_restart_bytes: got %0d expected %0d", cap_n - cap_base, N_TX); end
    endtask

    initial begin
        test_reset();
        test_basic_stream();
        test_address_timing();
        test_snapshot_hold();
        test_ignored_inputs();
        test_reset_mid_stream();
        checks++; if (both_n != 0) begin errors++; $display("FAIL start_done_overlap: got %0d cycles expected 0", both_n); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
